// File: rtl/mode_router.sv
// Mode manager for the stopwatch/clock board: holds the active mode, routes
// buttons to that mode only, and blanks button traffic after every mode change.
module mode_router #(
    parameter int NUM_MODES    = 4,
    parameter int NUM_BTN      = 4,
    parameter int DIGITS_W     = 16,
    parameter int MODE_BTN     = 3,
    parameter int GUARD_CYCLES = 16,
    localparam int MODE_W      = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BTN-1:0]            btn_clean,
    input  logic                          sw_direct,
    input  logic [MODE_W-1:0]             sw_mode,
    input  logic                          mode_lock,
    input  logic [NUM_MODES*DIGITS_W-1:0] numbers_in,
    output logic [NUM_MODES*NUM_BTN-1:0]  btn_out,
    output logic [DIGITS_W-1:0]           numbers,
    output logic [MODE_W-1:0]             mode,
    output logic                          mode_changed,
    output logic                          guard_active
);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_GUARD  = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;

    localparam int CNT_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [MODE_W:0]    MODES_L   = (MODE_W+1)'(NUM_MODES);
    localparam logic [MODE_W-1:0]  LAST_MODE = MODE_W'(NUM_MODES - 1);
    localparam logic [NUM_BTN-1:0] STEP_MASK = NUM_BTN'(1) << MODE_BTN;

    logic [1:0]                    state_r;
    logic [1:0]                    state_nxt_s;
    logic [CNT_W-1:0]              cnt_r;
    logic [CNT_W-1:0]              cnt_nxt_s;
    logic                          btn_prev_r;
    logic                          step_rise_s;
    logic                          req_s;
    logic [MODE_W-1:0]             target_s;
    logic [NUM_BTN-1:0]            btn_masked_s;
    logic [NUM_MODES*NUM_BTN-1:0]  btn_route_s;
    logic [DIGITS_W-1:0]           numbers_sel_s;
    logic [MODE_W-1:0]             mode_r;
    logic [NUM_MODES*NUM_BTN-1:0]  btn_out_r;
    logic [DIGITS_W-1:0]           numbers_r;
    logic                          mode_changed_r;
    logic                          guard_active_r;

    assign btn_masked_s = btn_clean & ~STEP_MASK;
    assign step_rise_s  = btn_clean[MODE_BTN] & ~btn_prev_r;

    // Mode-change request: button stepping with wrap, or an in-range direct select.
    always_comb begin
        req_s    = 1'b0;
        target_s = mode_r;
        if (mode_lock) begin
            req_s = 1'b0;
        end else if (!sw_direct) begin
            if (step_rise_s) begin
                req_s    = 1'b1;
                target_s = (mode_r == LAST_MODE) ? {MODE_W{1'b0}} : mode_r + MODE_W'(1);
            end else begin
                req_s = 1'b0;
            end
        end else if (({1'b0, sw_mode} < MODES_L) && (sw_mode != mode_r)) begin
            req_s    = 1'b1;
            target_s = sw_mode;
        end else begin
            req_s = 1'b0;
        end
    end

    // Guard sequencing; an accepted change always restarts the blanking window.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        if (req_s) begin
            state_nxt_s = (GUARD_CYCLES == 0) ? ST_WAIT : ST_GUARD;
            cnt_nxt_s   = CNT_LOAD;
        end else begin
            case (state_r)
                ST_ACTIVE: state_nxt_s = ST_ACTIVE;
                ST_GUARD: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_nxt_s = ST_WAIT;
                    end else begin
                        cnt_nxt_s = cnt_r - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (btn_masked_s == {NUM_BTN{1'b0}}) begin
                        state_nxt_s = ST_ACTIVE;
                    end else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                default: state_nxt_s = ST_WAIT;
            endcase
        end
    end

    // Button fan-out to the active mode's slice and display word selection.
    always_comb begin
        btn_route_s   = {(NUM_MODES*NUM_BTN){1'b0}};
        numbers_sel_s = {DIGITS_W{1'b0}};
        for (int k = 0; k < NUM_MODES; k++) begin
            if (mode_r == MODE_W'(k)) begin
                btn_route_s[k*NUM_BTN +: NUM_BTN] = btn_masked_s;
                numbers_sel_s                     = numbers_in[k*DIGITS_W +: DIGITS_W];
            end else begin
                btn_route_s[k*NUM_BTN +: NUM_BTN] = {NUM_BTN{1'b0}};
            end
        end
    end

    // State and output registers; btn_prev resets high so a held step button is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_WAIT;
            cnt_r          <= {CNT_W{1'b0}};
            btn_prev_r     <= 1'b1;
            mode_r         <= {MODE_W{1'b0}};
            btn_out_r      <= {(NUM_MODES*NUM_BTN){1'b0}};
            numbers_r      <= {DIGITS_W{1'b0}};
            mode_changed_r <= 1'b0;
            guard_active_r <= 1'b1;
        end else begin
            state_r        <= state_nxt_s;
            cnt_r          <= cnt_nxt_s;
            btn_prev_r     <= btn_clean[MODE_BTN];
            mode_r         <= target_s;
            btn_out_r      <= (state_r == ST_ACTIVE) ? btn_route_s : {(NUM_MODES*NUM_BTN){1'b0}};
            numbers_r      <= numbers_sel_s;
            mode_changed_r <= req_s;
            guard_active_r <= (state_nxt_s != ST_ACTIVE);
        end
    end

    assign mode         = mode_r;
    assign btn_out      = btn_out_r;
    assign numbers      = numbers_r;
    assign mode_changed = mode_changed_r;
    assign guard_active = guard_active_r;

endmodule

// File: tb/tb_mode_router.sv
// Self-checking bench for mode_router: vector table, directed corner sequences,
// and random traffic against a behavioural model.
module tb_mode_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  btn_clean = 4'd0;
    logic        sw_direct = 1'b0;
    logic [1:0]  sw_mode = 2'd0;
    logic        mode_lock = 1'b0;
    logic [63:0] numbers_in = 64'h4444_3333_2222_1111;
    logic [47:0] numbers_in3 = 48'hCCCC_BBBB_AAAA;

    logic [15:0] btn_out;
    logic [15:0] numbers;
    logic [1:0]  mode;
    logic        mode_changed;
    logic        guard_active;

    logic [11:0] btn_out3;
    logic [15:0] numbers3;
    logic [1:0]  mode3;
    logic        mode_changed3;
    logic        guard_active3;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mode_router dut (
        .clk(clk), .reset(reset), .btn_clean(btn_clean), .sw_direct(sw_direct),
        .sw_mode(sw_mode), .mode_lock(mode_lock), .numbers_in(numbers_in),
        .btn_out(btn_out), .numbers(numbers), .mode(mode),
        .mode_changed(mode_changed), .guard_active(guard_active)
    );

    mode_router #(.NUM_MODES(3), .GUARD_CYCLES(4)) dut3 (
        .clk(clk), .reset(reset), .btn_clean(btn_clean), .sw_direct(sw_direct),
        .sw_mode(sw_mode), .mode_lock(mode_lock), .numbers_in(numbers_in3),
        .btn_out(btn_out3), .numbers(numbers3), .mode(mode3),
        .mode_changed(mode_changed3), .guard_active(guard_active3)
    );

    // Behavioural model of the 4-mode, 16-cycle-guard instance
    int          m_mode;
    int          m_guard_left;
    bit          m_wait;
    bit          m_prev;
    logic [15:0] e_btn_out;
    logic [15:0] e_numbers;
    bit          e_changed;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int want;
        bit rise;
        if (reset) begin
            m_mode = 0; m_guard_left = 0; m_wait = 1'b1; m_prev = 1'b1;
            e_btn_out = 16'd0; e_numbers = 16'd0; e_changed = 1'b0;
        end else begin
            if (!m_wait && m_guard_left == 0)
                e_btn_out = 16'((btn_clean & 4'b0111) << (4 * m_mode));
            else
                e_btn_out = 16'd0;
            e_numbers = 16'((numbers_in >> (16 * m_mode)) & 64'hFFFF);
            rise   = btn_clean[3] && !m_prev;
            m_prev = btn_clean[3];
            want   = -1;
            if (!mode_lock) begin
                if (!sw_direct && rise) want = (m_mode + 1) % 4;
                else if (sw_direct && int'(sw_mode) != m_mode) want = int'(sw_mode);
            end
            e_changed = (want >= 0);
            if (want >= 0) begin
                m_mode = want; m_guard_left = 16; m_wait = 1'b1;
            end else if (m_guard_left > 0) begin
                m_guard_left--;
            end else if (m_wait && (btn_clean & 4'b0111) == 4'd0) begin
                m_wait = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_mode", 64'(mode), 64'(m_mode));
        chk("model_changed", 64'(mode_changed), 64'(e_changed));
        chk("model_guard", 64'(guard_active), 64'(m_wait || m_guard_left > 0));
        chk("model_btn_out", 64'(btn_out), 64'(e_btn_out));
        chk("model_numbers", 64'(numbers), 64'(e_numbers));
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  btn;
        bit          dir;
        logic [1:0]  sel;
        bit          lock;
        logic [1:0]  exp_mode;
        bit          exp_chg;
        bit          exp_guard;
        logic [15:0] exp_btn_out;
        logic [15:0] exp_numbers;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int cnt;
        vecs[0] = '{1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000, 16'h1111};
        vecs[2] = '{1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0002, 16'h1111};
        vecs[3] = '{1'b0, 4'b0110, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0006, 16'h1111};
        vecs[4] = '{1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 16'h0000, 16'h1111};
        vecs[5] = '{1'b0, 4'b1000, 1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000, 16'h2222};
        vecs[6] = '{1'b0, 4'b0000, 1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000, 16'h2222};
        vecs[7] = '{1'b0, 4'b0000, 1'b1, 2'd3, 1'b0, 2'd3, 1'b1, 1'b1, 16'h0000, 16'h2222};
        vecs[8] = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b1, 2'd3, 1'b0, 1'b1, 16'h0000, 16'h4444};

        for (int i = 0; i < 9; i++) begin
            reset = vecs[i].rst; btn_clean = vecs[i].btn; sw_direct = vecs[i].dir;
            sw_mode = vecs[i].sel; mode_lock = vecs[i].lock;
            step();
            chk($sformatf("vec%0d_mode", i), 64'(mode), 64'(vecs[i].exp_mode));
            chk($sformatf("vec%0d_chg", i), 64'(mode_changed), 64'(vecs[i].exp_chg));
            chk($sformatf("vec%0d_guard", i), 64'(guard_active), 64'(vecs[i].exp_guard));
            chk($sformatf("vec%0d_btn_out", i), 64'(btn_out), 64'(vecs[i].exp_btn_out));
            chk($sformatf("vec%0d_numbers", i), 64'(numbers), 64'(vecs[i].exp_numbers));
        end

        // Step wrap 1,2,3,0
        mode_lock = 1'b0; sw_direct = 1'b0; btn_clean = 4'd0; reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        for (int i = 1; i <= 4; i++) begin
            btn_clean = 4'b1000;
            step();
            chk("wrap_mode", 64'(mode), 64'(i % 4));
            chk("wrap_pulse", 64'(mode_changed), 64'd1);
            btn_clean = 4'b0000;
            step();
            chk("wrap_pulse_once", 64'(mode_changed), 64'd0);
            repeat (19) step();
        end

        // Held button across a change stays blanked until released
        btn_clean = 4'b0001;
        step();
        chk("held_before", 64'(btn_out), 64'h0001);
        btn_clean = 4'b1001;
        step();
        chk("held_step_mode", 64'(mode), 64'd1);
        btn_clean = 4'b0001;
        for (int i = 0; i < 21; i++) begin
            step();
            chk("held_blank", 64'(btn_out), 64'd0);
        end
        chk("held_guard", 64'(guard_active), 64'd1);
        btn_clean = 4'b0000;
        step();
        chk("release_active", 64'(guard_active), 64'd0);
        btn_clean = 4'b0001;
        step();
        chk("held_repress", 64'(btn_out), 64'h0010);
        btn_clean = 4'b0000;

        // Direct select, and out-of-range select on the 3-mode instance
        reset = 1'b1;
        step();
        reset = 1'b0; sw_direct = 1'b1; sw_mode = 2'd2;
        step();
        chk("direct_mode", 64'(mode), 64'd2);
        chk("direct_pulse", 64'(mode_changed), 64'd1);
        chk("direct3_mode", 64'(mode3), 64'd2);
        chk("direct3_pulse", 64'(mode_changed3), 64'd1);
        sw_mode = 2'd3;
        step();
        chk("direct_numbers", 64'(numbers), 64'h3333);
        chk("direct3_numbers", 64'(numbers3), 64'hCCCC);
        chk("range3_mode", 64'(mode3), 64'd2);
        chk("range3_pulse", 64'(mode_changed3), 64'd0);
        chk("range3_guard", 64'(guard_active3), 64'd1);
        chk("range3_btn_out", 64'(btn_out3), 64'd0);
        step();
        chk("range3_hold", 64'(mode3), 64'd2);

        // Lock discards the request; unlocking while held needs a fresh edge
        sw_direct = 1'b0;
        repeat (20) step();
        mode_lock = 1'b1; btn_clean = 4'b1000;
        step();
        chk("lock_mode", 64'(mode), 64'd3);
        chk("lock_pulse", 64'(mode_changed), 64'd0);
        mode_lock = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("unlock_held_mode", 64'(mode), 64'd3);
            chk("unlock_held_pulse", 64'(mode_changed), 64'd0);
        end
        btn_clean = 4'b0000;
        step();
        btn_clean = 4'b1000;
        step();
        chk("unlock_edge_mode", 64'(mode), 64'd0);
        btn_clean = 4'b0000;

        // Retrigger restarts a full guard window
        repeat (20) step();
        btn_clean = 4'b1000;
        step();
        btn_clean = 4'b0000;
        repeat (4) step();
        btn_clean = 4'b1000;
        step();
        chk("retrig_pulse", 64'(mode_changed), 64'd1);
        chk("retrig_mode", 64'(mode), 64'd2);
        btn_clean = 4'b0000;
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (!guard_active) break;
            cnt++;
        end
        chk("retrig_guard_len", 64'(cnt), 64'd17);

        // Reset in the middle of a guard window
        btn_clean = 4'b1000;
        step();
        btn_clean = 4'b0000;
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("midrst_mode", 64'(mode), 64'd0);
        chk("midrst_btn_out", 64'(btn_out), 64'd0);
        chk("midrst_numbers", 64'(numbers), 64'd0);
        chk("midrst_guard", 64'(guard_active), 64'd1);
        reset = 1'b0;

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            reset      = ($urandom_range(0, 149) == 0);
            btn_clean  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            if ($urandom_range(0, 24) == 0) sw_direct = ~sw_direct;
            if ($urandom_range(0, 9) == 0) sw_mode = 2'($urandom);
            mode_lock  = ($urandom_range(0, 7) == 0);
            numbers_in = {$urandom, $urandom};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
